// File: rtl/scarv_cop_palu_dispatch.sv
// rtl/scarv_cop_palu_dispatch.sv - issue/writeback sequencer driving the packed-ALU handshake
// Optional perf counters enabled by SCARV_COP_PALU_DISPATCH_PERF_EN.
module scarv_cop_palu_dispatch #(
  parameter int CPR_AW      = 4,
  parameter int WDOG_CYCLES = 63
) (
  input  logic              g_clk,
  input  logic              g_resetn,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [3:0]        id_class,
  input  logic [4:0]        id_subclass,
  input  logic [2:0]        id_pw,
  input  logic [31:0]       id_imm,
  input  logic [CPR_AW-1:0] id_crs1,
  input  logic [CPR_AW-1:0] id_crs2,
  input  logic [CPR_AW-1:0] id_crs3,
  input  logic [CPR_AW-1:0] id_crd,
  input  logic [31:0]       id_gpr_rs1,
  output logic [CPR_AW-1:0] cpr_ra1,
  output logic [CPR_AW-1:0] cpr_ra2,
  output logic [CPR_AW-1:0] cpr_ra3,
  input  logic [31:0]       cpr_rd1,
  input  logic [31:0]       cpr_rd2,
  input  logic [31:0]       cpr_rd3,
  output logic              palu_ivalid,
  input  logic              palu_idone,
  output logic [31:0]       palu_rs1,
  output logic [31:0]       palu_rs2,
  output logic [31:0]       palu_rs3,
  output logic [31:0]       gpr_rs1,
  output logic [31:0]       palu_id_imm,
  output logic [2:0]        palu_id_pw,
  output logic [3:0]        palu_id_class,
  output logic [4:0]        palu_id_subclass,
  input  logic [3:0]        palu_cpr_rd_ben,
  input  logic [31:0]       palu_cpr_rd_wdata,
  output logic [CPR_AW-1:0] cpr_wa,
  output logic [3:0]        cpr_wen,
  output logic [31:0]       cpr_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_wb,
  output logic              rsp_err
`ifdef SCARV_COP_PALU_DISPATCH_PERF_EN
  ,
  output logic [31:0]       perf_insn,
  output logic [31:0]       perf_busy
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, WB, RESP} state_t;

  localparam logic [7:0] WDOG_LAST = 8'(WDOG_CYCLES - 1);

  state_t            state, state_nxt;
  logic [7:0]        wdog_cnt;
  logic [CPR_AW-1:0] crd_q;
  logic [3:0]        ben_q;
  logic [31:0]       wdata_q;
  logic              err_q;
  logic              accept;
  logic              wdog_hit;

  assign cpr_ra1  = id_crs1;
  assign cpr_ra2  = id_crs2;
  assign cpr_ra3  = id_crs3;
  assign accept   = id_valid && id_ready;
  assign wdog_hit = (wdog_cnt == WDOG_LAST);

  always_ff @(posedge g_clk) begin
    if (!g_resetn) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    id_ready    = 1'b0;
    palu_ivalid = 1'b0;
    cpr_wen     = 4'h0;
    rsp_valid   = 1'b0;
    rsp_wb      = 1'b0;
    rsp_err     = 1'b0;
    case (state)
      IDLE: begin
        id_ready = 1'b1;
        if (id_valid) state_nxt = EXEC;
      end
      EXEC: begin
        palu_ivalid = 1'b1;
        if (palu_idone || wdog_hit) state_nxt = WB;
      end
      WB: begin
        cpr_wen   = ben_q;
        state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_wb    = |ben_q;
        rsp_err   = err_q;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cpr_wa    = crd_q;
  assign cpr_wdata = wdata_q;

  // Operands are captured once at accept, so a crd aliasing a crs sees the old value.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      wdog_cnt         <= 8'h0;
      crd_q            <= '0;
      ben_q            <= 4'h0;
      wdata_q          <= 32'h0;
      err_q            <= 1'b0;
      palu_rs1         <= 32'h0;
      palu_rs2         <= 32'h0;
      palu_rs3         <= 32'h0;
      gpr_rs1          <= 32'h0;
      palu_id_imm      <= 32'h0;
      palu_id_pw       <= 3'h0;
      palu_id_class    <= 4'h0;
      palu_id_subclass <= 5'h0;
    end else begin
      if (accept) begin
        palu_rs1         <= cpr_rd1;
        palu_rs2         <= cpr_rd2;
        palu_rs3         <= cpr_rd3;
        gpr_rs1          <= id_gpr_rs1;
        palu_id_imm      <= id_imm;
        palu_id_pw       <= id_pw;
        palu_id_class    <= id_class;
        palu_id_subclass <= id_subclass;
        crd_q            <= id_crd;
        wdog_cnt         <= 8'h0;
        err_q            <= 1'b0;
        ben_q            <= 4'h0;
      end
      if (state == EXEC) begin
        wdog_cnt <= wdog_cnt + 8'd1;
        if (palu_idone) begin
          ben_q   <= palu_cpr_rd_ben;
          wdata_q <= palu_cpr_rd_wdata;
        end else if (wdog_hit) begin
          err_q <= 1'b1;
          ben_q <= 4'h0;
        end
      end
    end
  end

`ifdef SCARV_COP_PALU_DISPATCH_PERF_EN
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      perf_insn <= 32'h0;
      perf_busy <= 32'h0;
    end else begin
      if (state == RESP && rsp_ready && perf_insn != 32'hFFFF_FFFF)
        perf_insn <= perf_insn + 32'd1;
      if (state != IDLE && perf_busy != 32'hFFFF_FFFF)
        perf_busy <= perf_busy + 32'd1;
    end
  end
`endif

endmodule

// File: doc/scarv_cop_palu_dispatch.md
Name: scarv_cop_palu_dispatch

Overview:
- Issue/writeback sequencer on the driving side of the packed-ALU handshake.
- Accepts one decoded coprocessor instruction from decode and reads its CPR operands.
- Drives palu_ivalid with operands held stable until palu_idone, which covers the multi-cycle multiplier.
- Commits the returned byte-enabled result to the CPR file, then returns a completion response to the host.

Parameters:
- CPR_AW, 4, CPR address width (16 CPRs).
- WDOG_CYCLES, 63, maximum cycles in EXEC before abort; legal range 1..255.

Ports:
- g_clk  in  1  clock.
- g_resetn  in  1  synchronous active-low reset.
- id_valid  in  1  decoded instruction valid.
- id_ready  out  1  dispatcher can accept.
- id_class  in  4  instruction class.
- id_subclass  in  5  instruction subclass.
- id_pw  in  3  pack width.
- id_imm  in  32  immediate.
- id_crs1 / id_crs2 / id_crs3 / id_crd  in  CPR_AW each  source and destination CPR indices.
- id_gpr_rs1  in  32  host GPR operand.
- cpr_ra1 / cpr_ra2 / cpr_ra3  out  CPR_AW each  CPR async read addresses (combinational from id_crs*).
- cpr_rd1 / cpr_rd2 / cpr_rd3  in  32 each  CPR read data.
- palu_ivalid  out  1  instruction valid to PALU.
- palu_idone  in  1  PALU complete.
- palu_rs1 / palu_rs2 / palu_rs3 / gpr_rs1  out  32 each  latched operands.
- palu_id_imm  out  32  latched immediate.
- palu_id_pw  out  3  latched pack width.
- palu_id_class  out  4  latched class.
- palu_id_subclass  out  5  latched subclass.
- palu_cpr_rd_ben  in  4  PALU result byte enables.
- palu_cpr_rd_wdata  in  32  PALU result data.
- cpr_wa  out  CPR_AW  CPR write address.
- cpr_wen  out  4  CPR write byte enables.
- cpr_wdata  out  32  CPR write data.
- rsp_valid  out  1  completion response valid.
- rsp_ready  in  1  host accepts response.
- rsp_wb  out  1  at least one byte was written.
- rsp_err  out  1  watchdog abort.

Behaviour:
- States: IDLE, EXEC, WB, RESP. Reset state is IDLE.
- Reset values: all registered outputs 0, including palu_ivalid, cpr_wen, rsp_valid, rsp_wb and rsp_err. id_ready=1 after the reset cycle.
- IDLE:
  - id_ready=1.
  - On id_valid && id_ready, latch cpr_rd1/2/3, id_gpr_rs1, id_imm, id_pw, id_class, id_subclass and id_crd; clear the watchdog counter; go to EXEC.
- EXEC:
  - palu_ivalid=1 and id_ready=0. All palu_* operand outputs are bit-stable for the whole of EXEC.
  - Counter increments each EXEC cycle.
  - palu_idone sampled high: latch palu_cpr_rd_ben and palu_cpr_rd_wdata; go to WB.
  - Counter reaches WDOG_CYCLES with palu_idone low: set err, force latched ben=0, go to WB.
  - palu_idone takes priority over the watchdog in the same cycle.
- WB:
  - palu_ivalid=0.
  - Exactly one cycle of cpr_wa=latched crd, cpr_wen=latched ben, cpr_wdata=latched data.
  - ben=0 (cmov not taken, or abort) gives cpr_wen=0 and no write.
  - Always go to RESP.
- RESP:
  - rsp_valid=1, rsp_wb=|ben, rsp_err=err.
  - Outputs are held stable while rsp_ready=0.
  - On rsp_ready, go to IDLE and clear rsp_valid.
- Latency: a combinational PALU op accepted at edge N gives palu_ivalid in cycle N+1, write in cycle N+2 and rsp_valid in cycle N+3. A multiplier op of k cycles stretches EXEC to k cycles.
- Accept is not allowed in RESP: strictly one instruction in flight, no back-to-back overlap.
- crd equal to any crs: operands were latched at accept, so the old value is used. No hazard logic is needed.
- g_resetn low in any state: next cycle IDLE, all outputs 0, no CPR write, pending response dropped.
- palu_idone while not in EXEC is ignored.

Optional Feature:
- Macro: SCARV_COP_PALU_DISPATCH_PERF_EN.
- Defined: adds output ports perf_insn (32) and perf_busy (32).
  - perf_insn increments on each RESP handshake.
  - perf_busy increments each cycle the state is not IDLE.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- PADD: crs1=1, crs2=2, crd=3; PALU model returns ben=F, wdata=32'h0000_0007 with idone the same cycle as ivalid -> ivalid high 1 cycle; cpr_wen=F, cpr_wa=3, wdata=7 at N+2; rsp_valid at N+3 with rsp_wb=1, rsp_err=0.
- Multiplier model with idone 5 cycles after ivalid -> palu_ivalid high exactly 5 cycles; palu_rs1/rs2 unchanged every cycle; write at the cycle after idone.
- CMOV not taken: model returns ben=0 -> cpr_wen=0 during WB; rsp_wb=0, rsp_err=0.
- WDOG_CYCLES=4, idone never asserted -> ivalid drops after 4 cycles; no write; rsp_err=1.
- Hold rsp_ready=0 for 10 cycles with id_valid=1 -> id_ready=0 throughout, rsp_valid and flags stable; next instruction accepted the cycle after rsp_ready.
- Assert g_resetn=0 mid-EXEC -> next cycle palu_ivalid=0, no cpr_wen pulse, rsp_valid=0, id_ready=1 after reset release.
